// File: rtl/w_ptr_full_gen.sv
// Write-side pointer and full-flag generator for the 10-deep Johnson-coded FIFO.
// Produces the write strobe/address, Johnson write pointer and full/almost-full/level/overflow status.
module w_ptr_full_gen #(
    parameter int SIZE     = 4,
    parameter int AF_LEVEL = 7
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            INC,
    input  logic [SIZE:0]   R_PTR,
    output logic            W_EN,
    output logic [SIZE-1:0] W_ADDR,
    output logic [SIZE:0]   W_PTR,
    output logic            W_FULL,
    output logic            W_AFULL,
    output logic [SIZE-1:0] W_LEVEL,
    output logic            W_OVF
);

    localparam int              DEPTH     = 2 * (SIZE + 1);
    localparam logic [SIZE:0]   DEPTH_P   = (SIZE+1)'(DEPTH);
    localparam logic [SIZE:0]   AF_P      = (SIZE+1)'(AF_LEVEL);
    localparam logic [SIZE-1:0] LAST_ADDR = SIZE'(DEPTH - 1);

    logic [SIZE:0]   rq1;
    logic [SIZE:0]   rq2;
    logic [SIZE:0]   ptr_nxt;
    logic [SIZE-1:0] addr_nxt;
    logic [SIZE:0]   level_nxt;
    logic            full_nxt;
    logic            afull_nxt;

    function automatic logic [SIZE:0] johnson_succ(input logic [SIZE:0] p);
        return {p[SIZE-1:0], ~p[SIZE]};
    endfunction

    // Position of a Johnson code in the sequence; illegal codes decode by the same rule.
    function automatic logic [SIZE:0] johnson_index(input logic [SIZE:0] p);
        logic [SIZE:0] ones;
        ones = '0;
        for (int i = 0; i <= SIZE; i++) begin
            ones = ones + {{SIZE{1'b0}}, p[i]};
        end
        return p[SIZE] ? (DEPTH_P - ones) : ones;
    endfunction

    assign W_EN = INC & ~W_FULL & ~RST;

    always_comb begin
        ptr_nxt   = W_PTR;
        addr_nxt  = W_ADDR;
        if (W_EN) begin
            ptr_nxt  = johnson_succ(W_PTR);
            addr_nxt = (W_ADDR == LAST_ADDR) ? '0 : W_ADDR + SIZE'(1);
        end
        level_nxt = johnson_index(ptr_nxt) + DEPTH_P - johnson_index(rq2);
        if (level_nxt >= DEPTH_P) begin
            level_nxt = level_nxt - DEPTH_P;
        end
        full_nxt  = (johnson_succ(ptr_nxt) == rq2);
        afull_nxt = (level_nxt >= AF_P);
    end

    // Status is recomputed every edge so read-side progress is seen without a write.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rq1     <= '0;
            rq2     <= '0;
            W_ADDR  <= '0;
            W_PTR   <= '0;
            W_LEVEL <= '0;
            W_FULL  <= 1'b0;
            W_AFULL <= 1'b0;
            W_OVF   <= 1'b0;
        end else begin
            rq1     <= R_PTR;
            rq2     <= rq1;
            W_ADDR  <= addr_nxt;
            W_PTR   <= ptr_nxt;
            W_LEVEL <= level_nxt[SIZE-1:0];
            W_FULL  <= full_nxt;
            W_AFULL <= afull_nxt;
            if (INC && W_FULL) begin
                W_OVF <= 1'b1;
            end
        end
    end

endmodule
